button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions the three raw game buttons before they reach the breakout game core.
- Per button: 2-FF synchroniser, then counter debounce, then one-cycle press pulse.
- Left/right also get auto-repeat step pulses for held paddle movement. Select never repeats.
- Sits between the top-level ui_in pins and the breakout core button inputs.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new level (>=1).
- REPEAT_DELAY, 10000000, cycles from press pulse to first repeat pulse (>=1).
- REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system/pixel clock.
- nRst  in  1  synchronous active-low reset.
- raw_left  in  1  asynchronous button, 1 = pressed.
- raw_right  in  1  asynchronous button, 1 = pressed.
- raw_select  in  1  asynchronous button, 1 = pressed.
- left_held  out  1  debounced level.
- right_held  out  1  debounced level.
- select_held  out  1  debounced level.
- left_step  out  1  one-cycle pulse: press or auto-repeat.
- right_step  out  1  one-cycle pulse: press or auto-repeat.
- select_press  out  1  one-cycle pulse on press only.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on nRst.
- While nRst=0 at a clk edge, every register clears: sync FFs, stable levels, counters, and all outputs (all outputs 0).
- Sync: s1 <= raw; s2 <= s1. All outputs are registered.
- Debounce, per channel:
  - s2==stable: cnt <= 0.
  - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Otherwise: cnt++.
  - cnt width is clog2(DEBOUNCE_CYCLES), minimum 1.
- Latency: a raw edge first sampled at edge k appears on *_held after edge k+DEBOUNCE_CYCLES+1. Same on release.
- Glitch or bounce shorter than DEBOUNCE_CYCLES: no output change. Any return to the stable value restarts the count.
- Press pulse: asserted exactly in the cycle where stable goes 0->1, coincident with *_held rising. No pulse on release.
- Auto-repeat (left/right only):
  - rcnt clears on the press edge and counts while held.
  - Pulse when rcnt reaches REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats); rcnt reloads to 0 after each pulse.
  - Step pulses occur at press P, P+REPEAT_DELAY, then +REPEAT_PERIOD each.
  - rcnt width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Release during the delay or period: rcnt clears, no further pulses.
- Re-press restarts the full delay.
- Channels are fully independent. Simultaneous left+right gives coincident pulses with no arbitration; the game core resolves them.
- Button held through reset: treated as a new press after reset, i.e. *_held and step/press pulse after DEBOUNCE_CYCLES+2 edges with nRst=1.
- Counters saturate by design and never wrap: they clear on every accept or pulse.

Decomposition:
- Shared package breakout_pkg holds:
  - button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_SELECT=2;
  - default cycle counts for a 25.175 MHz clock (10 ms debounce, 400 ms delay, 100 ms period).
- One natural sub-module: button_channel.
  - Contents: sync + debounce + press + optional repeat.
  - Parameter REPEAT_EN: 1 for left/right, 0 for select.
- button_conditioner instantiates button_channel three times.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; edges counted from first edge sampling the change):
- Reset with all raw=1 held, nRst=0 for 3 cycles:
  - all outputs 0 during reset;
  - after release, all *_held=1 at edge 6;
  - left_step, right_step and select_press each high exactly at edge 6.
- Glitch: raw_left=1 for 3 cycles, then 0 -> left_held and left_step stay 0 throughout.
- Bounce: raw_right toggles every 2 cycles for 10 cycles, then stays 1 (last toggle at edge T) -> single right_step at T+6, right_held=1 from T+6.
- Auto-repeat: raw_right held 60 cycles, then released:
  - right_step at edges 6, 26, 34, 42, 50, 58;
  - right_held falls 6 edges after release, with no pulse.
- Select held 100 cycles -> exactly one select_press at edge 6; select_held=1 throughout the remainder.
- raw_left and raw_right rise in the same cycle -> left_step and right_step coincident at 6, 26, 34. Asserting nRst=0 at cycle 30 clears everything next edge, with no pulse at 34.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared constants for the breakout button path: channel indices and nominal
// timing defaults for the 25.175 MHz pixel clock.
package breakout_pkg;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_COUNT  = 3;

  // Rounded cycle counts: ~10 ms debounce, ~400 ms repeat delay, ~100 ms period.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250_000;
  localparam int unsigned REPEAT_DELAY_DEFAULT    = 10_000_000;
  localparam int unsigned REPEAT_PERIOD_DEFAULT   = 2_500_000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, counter debounce, press pulse and optional
// auto-repeat of that pulse while the button stays held.
module button_channel
  import breakout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic raw,
  output logic held,
  output logic step
);

  localparam int unsigned CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          repeating;
  logic          accept, rise, rpt_hit;

  // A repeat is suppressed on the edge where the release is accepted.
  always_comb begin
    accept  = (s2 != held) && (cnt == CNT_LAST);
    rise    = accept && s2;
    rpt_hit = REPEAT_EN && held && !accept &&
              (rcnt == (repeating ? PER_LAST : DLY_LAST));
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      held      <= 1'b0;
      cnt       <= '0;
      rcnt      <= '0;
      repeating <= 1'b0;
      step      <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;

      if (s2 == held) begin
        cnt <= '0;
      end else if (accept) begin
        held <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      step <= rise || rpt_hit;

      if (!REPEAT_EN || !held || accept) begin
        rcnt      <= '0;
        repeating <= 1'b0;
      end else if (rpt_hit) begin
        rcnt      <= '0;
        repeating <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three raw game buttons: debounced levels for all, press/repeat
// steps for left/right, single press pulse for select.
module button_conditioner
  import breakout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic nRst,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_select,
  output logic left_held,
  output logic right_held,
  output logic select_held,
  output logic left_step,
  output logic right_step,
  output logic select_press
);

  logic [BTN_COUNT-1:0] raw, held, step;

  assign raw[BTN_LEFT]   = raw_left;
  assign raw[BTN_RIGHT]  = raw_right;
  assign raw[BTN_SELECT] = raw_select;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (i != BTN_SELECT)
    ) u_chan (
      .clk  (clk),
      .nRst (nRst),
      .raw  (raw[i]),
      .held (held[i]),
      .step (step[i])
    );
  end

  assign left_held    = held[BTN_LEFT];
  assign right_held   = held[BTN_RIGHT];
  assign select_held  = held[BTN_SELECT];
  assign left_step    = step[BTN_LEFT];
  assign right_step   = step[BTN_RIGHT];
  assign select_press = step[BTN_SELECT];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed edge numbers.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic raw_left = 1'b0, raw_right = 1'b0, raw_select = 1'b0;
  logic left_held, right_held, select_held, left_step, right_step, select_press;

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .raw_left     (raw_left),
    .raw_right    (raw_right),
    .raw_select   (raw_select),
    .left_held    (left_held),
    .right_held   (right_held),
    .select_held  (select_held),
    .left_step    (left_step),
    .right_step   (right_step),
    .select_press (select_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, ecount, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecount, act, exp);
    end
  endtask

  // Model: a new level is accepted once the last D synchronised samples taken
  // since the previous accept all disagree with the current level. Steps are
  // derived from the time elapsed since the press.
  bit       m_s1[3], m_s2[3], m_held[3], m_step[3];
  bit [D-1:0] m_win[3];
  int       m_since[3], m_press[3];
  bit       rep_en[3] = '{1'b1, 1'b1, 1'b0};

  always @(posedge clk) begin
    bit raw_now[3];
    bit nh;
    int d;
    raw_now[0] = raw_left;
    raw_now[1] = raw_right;
    raw_now[2] = raw_select;
    ecount++;
    for (int ch = 0; ch < 3; ch++) begin
      if (!nRst) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_held[ch] = 0; m_step[ch] = 0;
        m_win[ch] = '0; m_since[ch] = 0; m_press[ch] = 0;
      end else begin
        nh = m_held[ch];
        m_win[ch] = {m_win[ch][D-2:0], m_s2[ch]};
        m_since[ch]++;
        if (m_since[ch] >= D && m_win[ch] == {D{~m_held[ch]}}) begin
          nh = ~m_held[ch];
          m_since[ch] = 0;
        end
        if (nh && !m_held[ch]) begin
          m_press[ch] = ecount;
          m_step[ch]  = 1;
        end else if (nh && m_held[ch] && rep_en[ch]) begin
          d = ecount - m_press[ch];
          m_step[ch] = (d >= DLY) && ((d - DLY) % PER == 0);
        end else begin
          m_step[ch] = 0;
        end
        m_held[ch] = nh;
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw_now[ch];
      end
    end
  end

  always @(negedge clk) begin
    chk("model_left_held",    left_held,    m_held[0]);
    chk("model_right_held",   right_held,   m_held[1]);
    chk("model_select_held",  select_held,  m_held[2]);
    chk("model_left_step",    left_step,    m_step[0]);
    chk("model_right_step",   right_step,   m_step[1]);
    chk("model_select_press", select_press, m_step[2]);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int start, rel, t_last, n_steps, step_edge, hold_l[3];
    int rep_edges[$];
    int exp_rep[6] = '{6, 26, 34, 42, 50, 58};

    // Buttons held through reset.
    raw_left = 1; raw_right = 1; raw_select = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_zero", left_held | right_held | select_held |
                      left_step | right_step | select_press, 1'b0);
    end
    nRst = 1;
    start = ecount;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rel = ecount - start;
      chk("rst_left_held",   left_held,    rel >= 6);
      chk("rst_right_held",  right_held,   rel >= 6);
      chk("rst_select_held", select_held,  rel >= 6);
      chk("rst_left_step",   left_step,    rel == 6);
      chk("rst_right_step",  right_step,   rel == 6);
      chk("rst_select_pr",   select_press, rel == 6);
    end
    raw_left = 0; raw_right = 0; raw_select = 0;
    idle(12);

    // Glitch shorter than the debounce window.
    raw_left = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) raw_left = 0;
      chk("glitch_held", left_held, 1'b0);
      chk("glitch_step", left_step, 1'b0);
    end

    // Bounce: toggles every 2 cycles, last toggle at edge t_last.
    n_steps = 0; step_edge = -1; t_last = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 10) raw_right = ((i % 4) < 2);
      if (i == 8) t_last = ecount;
      @(negedge clk);
      if (right_step) begin n_steps++; step_edge = ecount; end
    end
    chk_int("bounce_steps", n_steps, 1);
    chk_int("bounce_edge", step_edge - t_last, 6);
    chk("bounce_held", right_held, 1'b1);
    raw_right = 0;
    idle(12);

    // Auto-repeat: 60 cycles held.
    raw_right = 1;
    start = ecount;
    rep_edges.delete();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      rel = ecount - start;
      if (right_step) rep_edges.push_back(rel);
      chk("rep_held", right_held, (rel >= 6) && (rel < 66));
      if (rel == 60) raw_right = 0;
    end
    chk_int("rep_count", rep_edges.size(), 6);
    for (int i = 0; i < 6; i++)
      chk_int("rep_edge", (i < rep_edges.size()) ? rep_edges[i] : -1, exp_rep[i]);

    // Select never repeats.
    raw_select = 1;
    start = ecount;
    n_steps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rel = ecount - start;
      if (select_press) n_steps++;
      chk("sel_press", select_press, rel == 6);
      chk("sel_held", select_held, rel >= 6);
    end
    chk_int("sel_count", n_steps, 1);
    raw_select = 0;
    idle(12);

    // Simultaneous left+right, reset mid-repeat.
    raw_left = 1; raw_right = 1;
    start = ecount;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      rel = ecount - start;
      chk("dual_left_step",  left_step,  (rel == 6) || (rel == 26));
      chk("dual_right_step", right_step, (rel == 6) || (rel == 26));
      chk("dual_left_held",  left_held,  (rel >= 6) && (rel <= 30));
      chk("dual_right_held", right_held, (rel >= 6) && (rel <= 30));
      if (rel == 30) begin nRst = 0; raw_left = 0; raw_right = 0; end
      if (rel == 33) nRst = 1;
    end

    // Random holds: mixture of bounces and long presses, occasional reset.
    hold_l = '{0, 0, 0};
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (hold_l[ch] == 0) begin
          hold_l[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5)
                                                   : $urandom_range(8, 70);
          case (ch)
            0: raw_left   = ~raw_left;
            1: raw_right  = ~raw_right;
            default: raw_select = ~raw_select;
          endcase
        end
        hold_l[ch]--;
      end
      nRst = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    nRst = 1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
